// File: rtl/slot_alloc_if.sv
// slot_alloc_if
//   Bundles the requester / free / status signals of slot_alloc_scheduler.
//   master: issue side (drives req, stall, flush, frees; observes grants/status)
//   slave : the scheduler itself
//   Signals:
//     req[REQ_COUNT]       level allocation requests
//     stall                freezes grants, rr pointer and cooldown count
//     flush                1-cycle pulse that starts the flush sequence
//     free_valid/free_slot slot release
//     grant[REQ_COUNT]     one-hot or zero, combinational
//     grant_slot[TAG_W]    slot handed to the granted requester
//     slot_valid           registered occupancy vector
//     busy_count           registered popcount of slot_valid
//     full                 busy_count == SLOT_COUNT
//     flushing             flush sequence in progress
//     flush_done           1-cycle pulse when the sequence completes
//     err_free             sticky: free of an unoccupied slot
interface slot_alloc_if #(
  parameter int SLOT_COUNT = 8,
  parameter int REQ_COUNT  = 4
);
  localparam int TAG_W = $clog2(SLOT_COUNT);

  logic [REQ_COUNT-1:0]  req;
  logic                  stall;
  logic                  flush;
  logic                  free_valid;
  logic [TAG_W-1:0]      free_slot;
  logic [REQ_COUNT-1:0]  grant;
  logic [TAG_W-1:0]      grant_slot;
  logic [SLOT_COUNT-1:0] slot_valid;
  logic [TAG_W:0]        busy_count;
  logic                  full;
  logic                  flushing;
  logic                  flush_done;
  logic                  err_free;

  modport master (
    output req, stall, flush, free_valid, free_slot,
    input  grant, grant_slot, slot_valid, busy_count, full, flushing, flush_done, err_free
  );

  modport slave (
    input  req, stall, flush, free_valid, free_slot,
    output grant, grant_slot, slot_valid, busy_count, full, flushing, flush_done, err_free
  );
endinterface

// File: rtl/slot_alloc_scheduler.sv
// slot_alloc_scheduler
//   Hands out SLOT_COUNT in-flight slots to REQ_COUNT requesters with
//   round-robin arbitration, owns the slot_valid occupancy vector and
//   sequences flush: stop grants -> drain until empty -> cooldown -> resume.
//   Ports:
//     clk_i  clock, all state on posedge
//     rst_i  synchronous active-high reset
//     bus    slot_alloc_if.slave (requests, frees, grants, status)
module slot_alloc_scheduler #(
  parameter int SLOT_COUNT = 8,
  parameter int REQ_COUNT  = 4,
  parameter int COOLDOWN   = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  slot_alloc_if.slave  bus
);
  localparam int TAG_W = $clog2(SLOT_COUNT);
  localparam int PTR_W = $clog2(REQ_COUNT);
  localparam int CNT_W = $clog2(COOLDOWN + 1);

  typedef enum logic [1:0] {RUN, DRAIN, COOL} state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SLOT_COUNT-1:0] slot_valid_q, slot_valid_d;
  logic [TAG_W:0]        busy_q, busy_d;
  logic                  flush_done_q, flush_done_d;
  logic                  err_q, err_d;

  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      scan_idx;
  logic                  slot_found;
  logic [TAG_W-1:0]      slot_idx;
  logic                  full;
  logic                  grant_any;
  logic                  free_ok;

  // Round-robin: first requester at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + i) % REQ_COUNT);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Lowest free slot, from the registered vector so a slot freed this
  // cycle only becomes grantable next cycle.
  always_comb begin
    slot_found = 1'b0;
    slot_idx   = '0;
    for (int s = 0; s < SLOT_COUNT; s++) begin
      if (!slot_found && !slot_valid_q[s]) begin
        slot_found = 1'b1;
        slot_idx   = TAG_W'(s);
      end
    end
  end

  assign full      = (busy_q == (TAG_W+1)'(SLOT_COUNT));
  assign grant_any = !rst_i && (state_q == RUN) && !bus.stall && !bus.flush &&
                     !full && win_found && slot_found;
  assign free_ok   = bus.free_valid && (int'(bus.free_slot) < SLOT_COUNT) &&
                     slot_valid_q[bus.free_slot];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_done_d = 1'b0;
    rr_ptr_d     = rr_ptr_q;
    slot_valid_d = slot_valid_q;
    busy_d       = busy_q;
    err_d        = err_q;

    case (state_q)
      RUN:   if (bus.flush) state_d = DRAIN;
      DRAIN: if (slot_valid_q == '0) begin
               state_d = COOL;
               cnt_d   = '0;
             end
      // The COOLDOWN-th unstalled cycle is the one on which the count
      // reaches COOLDOWN, so leave straight from it.
      COOL:  if (!bus.stall) begin
               if (cnt_q == CNT_W'(COOLDOWN - 1)) begin
                 state_d      = RUN;
                 flush_done_d = 1'b1;
                 cnt_d        = '0;
               end else begin
                 cnt_d = cnt_q + CNT_W'(1);
               end
             end
      default: state_d = RUN;
    endcase

    if (grant_any) begin
      slot_valid_d[slot_idx] = 1'b1;
      rr_ptr_d = PTR_W'((int'(win_idx) + 1) % REQ_COUNT);
    end
    // Grant targets an empty slot, free targets an occupied one: never the same bit.
    if (free_ok)             slot_valid_d[bus.free_slot] = 1'b0;
    else if (bus.free_valid) err_d = 1'b1;

    busy_d = busy_q + {{TAG_W{1'b0}}, grant_any} - {{TAG_W{1'b0}}, free_ok};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      slot_valid_q <= '0;
      busy_q       <= '0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      slot_valid_q <= slot_valid_d;
      busy_q       <= busy_d;
      flush_done_q <= flush_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.grant      = grant_any ? (REQ_COUNT'(1) << win_idx) : '0;
  assign bus.grant_slot = slot_idx;
  assign bus.slot_valid = slot_valid_q;
  assign bus.busy_count = busy_q;
  assign bus.full       = full;
  assign bus.flushing   = (state_q != RUN);
  assign bus.flush_done = flush_done_q;
  assign bus.err_free   = err_q;
endmodule
